// File: rtl/drums_pkg.sv
// Shared constants and types for the Drums Hero pad front end.
// Optional 2-FF pad synchronizer is enabled by defining DRUMS_PAD_SYNC_EN.
package drums_pkg;
    localparam int NUM_PADS        = 4;
    localparam int CLK_HZ          = 50_000_000;
    localparam int DEBOUNCE_CYCLES = CLK_HZ / 1000;

    typedef logic [NUM_PADS-1:0] pad_vec_t;
endpackage

// File: rtl/pad_debounce_channel.sv
// One pad channel: optional 2-FF synchronizer, stability counter, stable level register.
// DRUMS_PAD_SYNC_EN selects the synchronized sample; otherwise the raw input is compared directly.
module pad_debounce_channel
    import drums_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_level_next
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             w_sample;
    logic             w_level_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

`ifdef DRUMS_PAD_SYNC_EN
    logic r_s0;
    logic r_s1;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else begin
            r_s0 <= i_raw;
            r_s1 <= r_s0;
        end
    end

    assign w_sample = r_s1;
`else
    assign w_sample = i_raw;
`endif

    // Any sample that matches the accepted level clears progress, so bounces never accumulate.
    always_comb begin
        w_level_next = r_level;
        w_cnt_next   = r_cnt;
        if (w_sample == r_level) begin
            w_cnt_next = '0;
        end else if (r_cnt == CNT_LAST) begin
            w_level_next = w_sample;
            w_cnt_next   = '0;
        end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_level <= w_level_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign o_level      = r_level;
    assign o_level_next = w_level_next;
endmodule

// File: rtl/drum_pad_debouncer.sv
// Multi-channel pad synchronizer/debouncer with a registered any-pad-pressed flag.
// Define DRUMS_PAD_SYNC_EN for asynchronous pad inputs (adds the 2-FF synchronizer).
module drum_pad_debouncer
    import drums_pkg::*;
#(
    parameter int CHANNELS      = NUM_PADS,
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [CHANNELS-1:0] PadRaw,
    output logic [CHANNELS-1:0] PadLevel,
    output logic                PadAny
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    logic [CHANNELS-1:0] w_level;
    logic [CHANNELS-1:0] w_level_next;
    logic                r_pad_any;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        pad_debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_chan (
            .Clock        (Clock),
            .Reset_n      (Reset_n),
            .i_raw        (PadRaw[gi]),
            .o_level      (w_level[gi]),
            .o_level_next (w_level_next[gi])
        );
    end

    // Built from next-state levels so PadAny moves on the same edge as the causing PadLevel bit.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pad_any <= 1'b0;
        end else begin
            r_pad_any <= |w_level_next;
        end
    end

    assign PadLevel = w_level;
    assign PadAny   = r_pad_any;
endmodule
